// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } state_e;

   // LO value written on divide-by-zero; sliced to the operand width by users.
   localparam logic [63:0] DIV0_LO = '1;

   function automatic logic is_div_op(input op_e op);
      return op[1];
   endfunction

   function automatic logic is_signed_op(input op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the CPU controller and the multiply/divide unit.
interface mdu_sequencer_if #(
   parameter int unsigned WIDTH = 32
) ();
   import mdu_pkg::*;

   logic             start;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             hi_w;
   logic             lo_w;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, hi_w, lo_w, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, hi_w, lo_w, div_zero
   );

endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on {acc, sr}.
module mdu_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] sr_nxt
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH-1:0] trial;
   logic             take;

   always_comb begin
      addend = sr[0] ? opnd : '0;
      sum    = {1'b0, acc} + {1'b0, addend};
      rem_s  = {acc, sr[WIDTH-1]};
      // Only used when rem_s >= opnd, so the result always fits in WIDTH bits.
      trial  = rem_s[WIDTH-1:0] - opnd;
      take   = (rem_s >= {1'b0, opnd});

      if (is_div) begin
         acc_nxt = take ? trial : rem_s[WIDTH-1:0];
         sr_nxt  = {sr[WIDTH-2:0], take};
      end else begin
         acc_nxt = sum[WIDTH:1];
         sr_nxt  = {sum[0], sr[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU unit writing HI/LO; sign handled around an unsigned core.
// Optional MDU_EARLY_TERM_EN: multiply finishes early once the remaining multiplier bits are zero.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic          clk,
   input logic          reset,
   mdu_sequencer_if.slave bus
);

   state_e           state_q;
   logic             is_div_q;
   logic             is_signed_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;
   logic             div_zero_q;

   logic [WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]   sr_nxt;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [2*WIDTH-1:0] prod;
   logic               early_stop;

   // sr_q/opnd_q hold the raw a/b between IDLE and PREP.
   assign a_abs = (is_signed_q && sr_q[WIDTH-1])   ? -sr_q   : sr_q;
   assign b_abs = (is_signed_q && opnd_q[WIDTH-1]) ? -opnd_q : opnd_q;
   assign prod  = {acc_q, sr_q};

`ifdef MDU_EARLY_TERM_EN
   logic [WIDTH-1:0] rem_mask;
   // Low cnt_q bits of sr_q are the multiplier bits not yet consumed.
   assign rem_mask   = (WIDTH'(1) << cnt_q) - WIDTH'(1);
   assign early_stop = !is_div_q && ((sr_q & rem_mask) == '0);
`else
   assign early_stop = 1'b0;
`endif

   mdu_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .is_div  (is_div_q),
      .acc     (acc_q),
      .sr      (sr_q),
      .opnd    (opnd_q),
      .acc_nxt (acc_nxt),
      .sr_nxt  (sr_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         is_div_q    <= 1'b0;
         is_signed_q <= 1'b0;
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         acc_q       <= '0;
         sr_q        <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  is_div_q    <= is_div_op(bus.op);
                  is_signed_q <= is_signed_op(bus.op);
                  sr_q        <= bus.a;
                  opnd_q      <= bus.b;
                  busy_q      <= 1'b1;
                  state_q     <= ST_PREP;
               end
            end
            ST_PREP: begin
               neg_quot_q <= is_signed_q & (sr_q[WIDTH-1] ^ opnd_q[WIDTH-1]);
               neg_rem_q  <= is_signed_q & sr_q[WIDTH-1];
               acc_q      <= '0;
               cnt_q      <= CNT_W'(WIDTH);
               if (is_div_q && (opnd_q == '0)) begin
                  hi_q       <= sr_q;
                  lo_q       <= DIV0_LO[WIDTH-1:0];
                  div_zero_q <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  sr_q    <= is_div_q ? a_abs : b_abs;
                  opnd_q  <= is_div_q ? b_abs : a_abs;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (early_stop) begin
                  {acc_q, sr_q} <= {acc_q, sr_q} >> cnt_q;
                  state_q       <= ST_FIX;
               end else begin
                  acc_q <= acc_nxt;
                  sr_q  <= sr_nxt;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (is_div_q) begin
                  hi_q <= neg_rem_q  ? -acc_q : acc_q;
                  lo_q <= neg_quot_q ? -sr_q  : sr_q;
               end else begin
                  {hi_q, lo_q} <= neg_quot_q ? -prod : prod;
               end
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.hi_w     = done_q;
   assign bus.lo_w     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed cases, ignored starts, reset abort, random ops.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mdu_sequencer_if #(.WIDTH(W)) bus ();

   mdu_sequencer #(
      .WIDTH(W),
      .CNT_W(6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          issue;
      int          lat;
      logic        is_mul;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural operands.
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint sa, sb_, p, q, r;
      longint unsigned up;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      dz = 1'b0;
      case (o)
         2'b00: begin p = sa * sb_; hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin up = {32'h0, a} * {32'h0, b}; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (o == 2'b10) begin
               q = sa / sb_; r = sa % sb_; hi = r[31:0]; lo = q[31:0];
            end else begin
               hi = a % b; lo = a / b;
            end
         end
      endcase
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done);
      exp_t e;
      int   n;
      n = 0;
      while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", (n < 200), 1);
      @(posedge clk);
      #1;
      model(o, a, b, e.hi, e.lo, e.dz);
      e.issue  = cyc;
      e.lat    = e.dz ? 2 : 35;
      e.is_mul = ~o[1];
      if (expect_done) sb.push_back(e);
      bus.start = 1'b1;
      bus.op    = op_e'(o);
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Monitor: compare every done pulse against the scoreboard head.
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_done) chk("done_width", bus.done, 0);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("hi", bus.hi, e.hi);
               chk("lo", bus.lo, e.lo);
               chk("div_zero", bus.div_zero, e.dz);
               chk("hi_w", bus.hi_w, 1);
               chk("lo_w", bus.lo_w, 1);
               chk("busy_at_done", bus.busy, 1);
`ifdef MDU_EARLY_TERM_EN
               if (e.is_mul) chk("latency_max", ((cyc - e.issue) <= 35), 1);
               else chk("latency", cyc - e.issue, e.lat);
`else
               chk("latency", cyc - e.issue, e.lat);
`endif
            end
         end
         prev_done = (bus.done === 1'b1);
      end
   end

   initial begin
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int          n;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_hi_w", bus.hi_w, 0);
      chk("rst_lo_w", bus.lo_w, 0);
      chk("rst_div_zero", bus.div_zero, 0);
      reset = 1'b1;

      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(2'b11, 32'd100, 32'd7, 1'b1);
      issue(2'b11, 32'd100, 32'd0, 1'b1);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      // Starts during a running MULT must be dropped.
      issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_ignore1", bus.busy, 1);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd55; bus.b = 32'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("busy_ignore2", bus.busy, 1);
      bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4;
      @(posedge clk);
      #1;
      bus.start = 1'b0;

      // Reset during CALC aborts with no write strobe.
      issue(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_hi", bus.hi, 0);
      chk("abort_lo", bus.lo, 0);
      chk("abort_hi_w", bus.hi_w, 0);
      chk("abort_done", bus.done, 0);
      reset = 1'b1;
      issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         case ($urandom_range(0, 9))
            0: rb = 32'h0;
            1: rb = $urandom_range(1, 15);
            2: rb = 32'hFFFF_FFFF;
            3: rb = $urandom_range(0, 3);
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb, 1'b1);
      end

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
